// File: rtl/puf_pkg.sv
// Shared PUF constants and state encoding for the pair comparator and counter bank.
// Latency: n/a (types, constants and elaboration helpers only).
// Backpressure: n/a.
package puf_pkg;

  // Defaults shared with the RO counter bank so both sides agree on packing.
  localparam int unsigned PUF_CNT_W     = 32;
  localparam int unsigned PUF_NUM_PAIRS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for n pairs; a single pair still gets a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/puf_pair_compare_seq_if.sv
// Request/response bundle between the RO counter bank, the pair comparator and the helper-data logic.
// Latency: n/a (wires only).
// Backpressure: response side uses resp_valid/resp_ready; start is a single-cycle request, dropped while busy.
// Ports: start, count0_bus, count1_bus, margin, resp_ready (master -> slave);
//        busy, resp_valid, response, unstable (slave -> master).
interface puf_pair_compare_seq_if
  import puf_pkg::*;
#(
  parameter int unsigned CNT_W     = PUF_CNT_W,
  parameter int unsigned NUM_PAIRS = PUF_NUM_PAIRS
) ();

  logic                         start;
  logic [NUM_PAIRS*CNT_W-1:0]   count0_bus;
  logic [NUM_PAIRS*CNT_W-1:0]   count1_bus;
  logic [CNT_W-1:0]             margin;
  logic                         busy;
  logic                         resp_valid;
  logic                         resp_ready;
  logic [NUM_PAIRS-1:0]         response;
  logic [NUM_PAIRS-1:0]         unstable;

  // Requester / response consumer side.
  modport master (
    output start, count0_bus, count1_bus, margin, resp_ready,
    input  busy, resp_valid, response, unstable
  );

  // Comparator side.
  modport slave (
    input  start, count0_bus, count1_bus, margin, resp_ready,
    output busy, resp_valid, response, unstable
  );

endinterface

// File: rtl/pair_diff_cmp.sv
// Single RO pair comparison: winner bit plus "difference below margin" reliability flag.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (counts), margin -> winner (0 when a > b, ties give 1), unstable (|a-b| < margin).
module pair_diff_cmp
  import puf_pkg::*;
#(
  parameter int unsigned CNT_W = PUF_CNT_W
) (
  input  logic [CNT_W-1:0] a,
  input  logic [CNT_W-1:0] b,
  input  logic [CNT_W-1:0] margin,
  output logic             winner,
  output logic             unstable
);

  logic             a_gt_b;
  logic [CNT_W-1:0] diff;

  assign a_gt_b = (a > b);

  // Subtract the smaller from the larger so the magnitude never wraps,
  // even for full-scale operands.
  assign diff = a_gt_b ? (a - b) : (b - a);

  assign winner   = ~a_gt_b;
  // margin == 0 can never trip this; a tie trips it for any margin >= 1.
  assign unstable = (diff < margin);

endmodule

// File: rtl/puf_pair_compare_seq.sv
// Snapshots NUM_PAIRS RO count pairs on start and compares one pair per cycle into response/unstable.
// Latency: resp_valid rises NUM_PAIRS+1 cycles after the start edge.
// Backpressure: result held in DONE until resp_valid & resp_ready; start ignored while busy.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries start, counts, margin,
//        busy, resp_valid/resp_ready, response, unstable.
module puf_pair_compare_seq
  import puf_pkg::*;
#(
  parameter int unsigned CNT_W     = PUF_CNT_W,
  parameter int unsigned NUM_PAIRS = PUF_NUM_PAIRS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  puf_pair_compare_seq_if.slave bus
);

  localparam int unsigned      IDX_W    = idx_width(NUM_PAIRS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAIRS - 1);

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0]                idx_q;
  logic [NUM_PAIRS-1:0][CNT_W-1:0] c0_q;
  logic [NUM_PAIRS-1:0][CNT_W-1:0] c1_q;
  logic [CNT_W-1:0]                margin_q;
  logic [NUM_PAIRS-1:0]            resp_q;
  logic [NUM_PAIRS-1:0]            unst_q;
  logic                            valid_q;

  logic             capture_en;
  logic             cmp_en;
  logic             valid_d;
  logic             busy_o;
  logic             hs;
  logic             last_pair;
  logic [CNT_W-1:0] cur_a;
  logic [CNT_W-1:0] cur_b;
  logic             cur_win;
  logic             cur_unst;

  assign hs        = valid_q & bus.resp_ready;
  assign last_pair = (idx_q == LAST_IDX);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = CMP;
      CMP:  if (last_pair) state_d = DONE;
      // Leave only once the registered valid has actually been seen by the consumer.
      DONE: if (hs)        state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    capture_en = 1'b0;
    cmp_en     = 1'b0;
    valid_d    = 1'b0;
    busy_o     = 1'b0;
    unique case (state_q)
      IDLE: capture_en = bus.start;
      CMP: begin
        cmp_en = 1'b1;
        busy_o = 1'b1;
      end
      DONE: begin
        valid_d = ~hs;
        busy_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- snapshot
  // Counts and margin are frozen at start so the bank may keep counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_q     <= '0;
      c1_q     <= '0;
      margin_q <= '0;
    end else if (capture_en) begin
      c0_q     <= bus.count0_bus;
      c1_q     <= bus.count1_bus;
      margin_q <= bus.margin;
    end
  end

  // ---------------------------------------------------------------- index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (capture_en) begin
      idx_q <= '0;
    end else if (cmp_en && !last_pair) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------- compare
  assign cur_a = c0_q[idx_q];
  assign cur_b = c1_q[idx_q];

  pair_diff_cmp #(
    .CNT_W (CNT_W)
  ) u_pair_diff_cmp (
    .a        (cur_a),
    .b        (cur_b),
    .margin   (margin_q),
    .winner   (cur_win),
    .unstable (cur_unst)
  );

  // ---------------------------------------------------------------- results
  // Bits are overwritten one by one; earlier results persist until replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= '0;
      unst_q <= '0;
    end else if (cmp_en) begin
      resp_q[idx_q] <= cur_win;
      unst_q[idx_q] <= cur_unst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign bus.busy       = busy_o;
  assign bus.resp_valid = valid_q;
  assign bus.response   = resp_q;
  assign bus.unstable   = unst_q;

endmodule

// File: tb/tb_puf_pair_compare_seq.sv
module tb_puf_pair_compare_seq;

  localparam int unsigned CW = 32;
  localparam int unsigned NP = 4;
  localparam int unsigned LAT = NP + 1;

  logic clk;
  logic rst_n;

  puf_pair_compare_seq_if #(.CNT_W(CW), .NUM_PAIRS(NP)) bus ();

  puf_pair_compare_seq #(
    .CNT_W     (CW),
    .NUM_PAIRS (NP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [CW-1:0] c0 [NP];
  logic [CW-1:0] c1 [NP];
  logic [NP-1:0] exp_r;
  logic [NP-1:0] exp_u;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: winner and reliability straight from the rules, using 64-bit
  // signed arithmetic so the magnitude can never wrap.
  task automatic model(input logic [CW-1:0] m, output logic [NP-1:0] r, output logic [NP-1:0] u);
    longint d;
    for (int i = 0; i < NP; i++) begin
      r[i] = (c0[i] > c1[i]) ? 1'b0 : 1'b1;
      d = longint'({32'h0, c0[i]}) - longint'({32'h0, c1[i]});
      if (d < 0) d = -d;
      u[i] = (d < longint'({32'h0, m})) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic drive_counts();
    for (int i = 0; i < NP; i++) begin
      bus.count0_bus[i*CW +: CW] = c0[i];
      bus.count1_bus[i*CW +: CW] = c1[i];
    end
  endtask

  // Drives the request, computes the expected result, returns #1 after the start edge.
  task automatic launch(input logic [CW-1:0] m);
    model(m, exp_r, exp_u);
    drive_counts();
    bus.margin = m;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    chk({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
    while (bus.resp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(LAT));
    chk({tag, "_resp"}, 64'(bus.response), 64'(exp_r));
    chk({tag, "_unst"}, 64'(bus.unstable), 64'(exp_u));
  endtask

  task automatic handshake(input string tag, input bit with_start);
    bus.resp_ready = 1'b1;
    bus.start      = with_start;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    bus.start      = 1'b0;
    chk({tag, "_valid_low"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    if (with_start) begin
      @(posedge clk); #1;
      chk({tag, "_hs_start_ignored"}, 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic rand_counts();
    for (int i = 0; i < NP; i++) begin
      c0[i] = $urandom;
      case ($urandom_range(0, 3))
        0: c1[i] = c0[i];
        1: c1[i] = c0[i] + $urandom_range(0, 20);
        2: c1[i] = c0[i] - $urandom_range(0, 20);
        default: c1[i] = $urandom;
      endcase
    end
  endtask

  initial begin
    logic [CW-1:0] m;
    logic [CW-1:0] t;
    vectors     = 0;
    miscompares = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.resp_ready = 1'b0;
    bus.margin     = '0;
    bus.count0_bus = '0;
    bus.count1_bus = '0;

    #3;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp", 64'(bus.response), 64'd0);
    chk("rst_unst", 64'(bus.unstable), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed plan: margin 0, 11, 10.
    c0[0] = 100; c0[1] = 50; c0[2] = 7; c0[3] = 7;
    c1[0] = 90;  c1[1] = 60; c1[2] = 7; c1[3] = 0;
    launch(32'd0);
    chk("dir_m0_exp_r", 64'(exp_r), 64'h6);
    wait_valid("dir_m0");
    handshake("dir_m0", 1'b0);
    launch(32'd11);
    chk("dir_m11_exp_u", 64'(exp_u), 64'hF);
    wait_valid("dir_m11");
    handshake("dir_m11", 1'b0);
    launch(32'd10);
    chk("dir_m10_exp_u", 64'(exp_u), 64'hC);
    wait_valid("dir_m10");
    handshake("dir_m10", 1'b1);

    // Full-scale extremes, both operand orders, margin at maximum.
    c0[0] = 32'hFFFF_FFFF; c1[0] = 32'h0;
    c0[1] = 32'h0;         c1[1] = 32'hFFFF_FFFF;
    c0[2] = $urandom;      c1[2] = $urandom;
    c0[3] = 32'hFFFF_FFFF; c1[3] = 32'hFFFF_FFFF;
    launch(32'hFFFF_FFFF);
    wait_valid("extreme");
    chk("extreme_bits01", 64'({bus.unstable[1:0], bus.response[1:0]}), 64'b00_10);
    handshake("extreme", 1'b0);

    // Backpressure with ignored start pulses.
    rand_counts();
    launch(32'($urandom_range(0, 25)));
    wait_valid("bp");
    for (int k = 0; k < 20; k++) begin
      if (k == 3 || k == 10) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("bp_valid_hold", 64'(bus.resp_valid), 64'd1);
      chk("bp_busy_hold", 64'(bus.busy), 64'd1);
      chk("bp_resp_hold", 64'({bus.unstable, bus.response}), 64'({exp_u, exp_r}));
    end
    handshake("bp", 1'b0);
    rand_counts();
    launch(32'($urandom_range(0, 25)));
    wait_valid("bp_next");
    handshake("bp_next", 1'b0);

    // Snapshot: inputs scrambled right after capture.
    rand_counts();
    launch(32'($urandom_range(0, 25)));
    for (int i = 0; i < NP; i++) begin
      t = $urandom;
      bus.count0_bus[i*CW +: CW] = t;
      bus.count1_bus[i*CW +: CW] = ~t;
    end
    bus.margin = 32'hFFFF_FFFF;
    wait_valid("snap");
    handshake("snap", 1'b0);

    // Reset in the middle of CMP.
    rand_counts();
    c0[0] = 32'd5; c1[0] = 32'd9;
    launch(32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_valid", 64'(bus.resp_valid), 64'd0);
    chk("midrst_resp", 64'(bus.response), 64'd0);
    chk("midrst_unst", 64'(bus.unstable), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    rand_counts();
    launch(32'($urandom_range(0, 25)));
    wait_valid("post_rst");
    handshake("post_rst", 1'b0);

    // Random regression.
    for (int r = 0; r < 12; r++) begin
      rand_counts();
      m = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 25));
      launch(m);
      wait_valid("rand");
      handshake("rand", 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
